btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//  Input-conditioning stage directly upstream of the 3-bit counter core in TOP.
//  - Synchronises N_CH raw pad inputs (ui_in bits) and debounces each channel.
//  - Emits a clean level plus single-cycle rise/fall pulses per channel.
//  - Queues rising edges as events behind a valid/ready handshake for the counter to consume.
// PARAMETERS
//  N_CH         4   number of input channels
//  SYNC_STAGES  2   synchroniser flops per channel (>=2)
//  DEB_LIMIT    4   consecutive stable cycles needed to accept a new level (>=1)
//  CNT_W        16  debounce counter width; must hold DEB_LIMIT-1
// PORTS
//  clk        in   1               system clock; all state changes on rising edge
//  rst_n      in   1               synchronous reset, active low
//  ena        in   1               design enable
//  btn_raw    in   N_CH            asynchronous raw inputs
//  btn_level  out  N_CH            debounced level
//  btn_rise   out  N_CH            one-cycle pulse on accepted 0->1
//  btn_fall   out  N_CH            one-cycle pulse on accepted 1->0
//  evt_valid  out  1               a rise event is pending
//  evt_id     out  $clog2(N_CH)    channel of the presented event
//  evt_ready  in   1               consumer accepts the event this cycle
//  evt_ovf    out  1               sticky: a rise was lost to coalescing
// BEHAVIOUR
//  Reset (rst_n=0 at an edge)
//  - All sync flops, counters, btn_level, btn_rise, btn_fall, pending bits and evt_ovf go to 0.
//  - Reset overrides everything, including mid-count and mid-handshake.
//  Synchroniser
//  - Free-running shift chain, clocked even when ena=0.
//  - sync[i] is the last stage of the chain.
//  Debounce, per channel
//  - mismatch = sync[i] != btn_level[i].
//  - mismatch=0: cnt[i] <= 0.
//  - mismatch=1, cnt < DEB_LIMIT-1: cnt[i] <= cnt[i]+1.
//  - mismatch=1, cnt == DEB_LIMIT-1: btn_level[i] <= sync[i]; cnt[i] <= 0.
//  - cnt never exceeds DEB_LIMIT-1. Any single agreeing cycle restarts the count (glitch rejection).
//  - Latency: raw held stable from sampling edge 0 -> level changes after edge SYNC_STAGES+DEB_LIMIT-1.
//  Pulses
//  - btn_rise/btn_fall are registered in the same edge as the level change.
//  - Each is high exactly one cycle; otherwise 0.
//  ena=0
//  - Counters and btn_level hold; btn_rise/btn_fall forced 0.
//  - Pending bits hold; handshake still operates.
//  - Counting resumes from the held cnt when ena returns high.
//  Event queue
//  - pending[i] is set on btn_rise[i].
//  - evt_valid = |pending; evt_id = lowest set index (combinational from pending regs).
//  - Transfer = evt_valid & evt_ready: pending[evt_id] cleared at that edge.
//  - Next event is presented the following cycle.
//  - Rise on a channel with pending already 1 and not being cleared: coalesced, evt_ovf <= 1.
//  - Rise on the channel being cleared in the same cycle: set wins, pending stays 1, no ovf.
//  - evt_ovf is cleared only by reset.
//  - evt_id and evt_valid are only meaningful together; evt_id=0 when evt_valid=0.
// TESTING (SYNC_STAGES=2, DEB_LIMIT=4, N_CH=4)
//  1. Reset with btn_raw=0, hold 10 cycles -> all outputs 0, evt_valid=0, evt_ovf=0.
//  2. btn_raw[0] 0->1 held -> btn_level[0]=1 and btn_rise[0]=1 for one cycle after edge 5;
//     evt_valid=1, evt_id=0; ready=1 -> evt_valid=0 next cycle.
//  3. btn_raw[1] toggles every 2 cycles for 20 cycles, then 0 -> btn_level[1] stays 0, no pulses, no events.
//  4. btn_raw[2] and btn_raw[0] rise together, evt_ready=1 -> evt_id=0, then evt_id=2 next cycle,
//     then evt_valid=0.
//  5. evt_ready=0; ch0 press, release (fall pulse seen), press again -> evt_ovf=1;
//     exactly one event (id 0) delivered once ready=1.
//  6. ena=0 at cnt=2 for 10 cycles -> level and cnt held, no pulses; ena=1 -> level changes 2 cycles later.
//     rst_n=0 mid-count -> all state 0 at the next edge.

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and edge-detect raw button inputs, queue rise events
//  clk        system clock
//  rst_n      synchronous reset, active low
//  ena        enable for debounce counting and edge pulses
//  btn_raw    asynchronous raw inputs
//  btn_level  debounced level per channel
//  btn_rise   one-cycle pulse on accepted 0->1
//  btn_fall   one-cycle pulse on accepted 1->0
//  evt_valid  a rise event is pending
//  evt_id     lowest pending channel (0 when nothing pending)
//  evt_ready  consumer accepts the presented event
//  evt_ovf    sticky, a rise was coalesced into an already pending event
module btn_conditioner #(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_LIMIT   = 4,
   parameter int CNT_W       = 16,
   parameter int ID_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic [N_CH-1:0] btn_raw,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_rise,
   output logic [N_CH-1:0] btn_fall,
   output logic            evt_valid,
   output logic [ID_W-1:0] evt_id,
   input  logic            evt_ready,
   output logic            evt_ovf
);
   logic [N_CH-1:0]  sync_q [SYNC_STAGES];
   logic [CNT_W-1:0] cnt [N_CH];
   logic [CNT_W-1:0] cnt_nxt [N_CH];
   logic [N_CH-1:0]  sync, mism, hit, lvl_nxt, rise_nxt, fall_nxt;
   logic [N_CH-1:0]  pending, clr, pend_nxt;
   logic             ovf_nxt;

   assign sync = sync_q[SYNC_STAGES-1];
   assign mism = sync ^ btn_level;

   // a channel flips only after DEB_LIMIT consecutive enabled mismatch cycles
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         hit[i]      = mism[i] && (cnt[i] == CNT_W'(DEB_LIMIT - 1));
         cnt_nxt[i]  = !ena ? cnt[i] : (!mism[i] || hit[i]) ? '0 : cnt[i] + CNT_W'(1);
         lvl_nxt[i]  = (ena && hit[i]) ? sync[i] : btn_level[i];
         rise_nxt[i] = ena && hit[i] && sync[i];
         fall_nxt[i] = ena && hit[i] && !sync[i];
      end
   end

   always_comb begin
      evt_id = '0;
      for (int i = N_CH - 1; i >= 0; i--)
         if (pending[i]) evt_id = ID_W'(i);
   end

   assign evt_valid = |pending;
   assign clr       = (evt_valid && evt_ready) ? (N_CH'(1) << evt_id) : '0;
   // a new rise beats a same-cycle clear; a rise onto a still-pending bit is lost
   assign pend_nxt  = (pending & ~clr) | rise_nxt;
   assign ovf_nxt   = evt_ovf | (|(rise_nxt & pending & ~clr));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
         btn_level <= '0;
         btn_rise  <= '0;
         btn_fall  <= '0;
         pending   <= '0;
         evt_ovf   <= 1'b0;
      end else begin
         sync_q[0] <= btn_raw;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_nxt[i];
         btn_level <= lvl_nxt;
         btn_rise  <= rise_nxt;
         btn_fall  <= fall_nxt;
         pending   <= pend_nxt;
         evt_ovf   <= ovf_nxt;
      end
   end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: vector table, directed corner cases and random stimulus against a reference model
module tb_btn_conditioner;
   localparam int DEB = 4;
   localparam int SS  = 2;

   logic       clk = 0, rst_n = 0, ena = 0, evt_ready = 0;
   logic [3:0] btn_raw = '0;
   logic [3:0] btn_level, btn_rise, btn_fall;
   logic       evt_valid, evt_ovf;
   logic [1:0] evt_id;
   int         n_chk = 0, n_pass = 0;

   btn_conditioner #(.N_CH(4), .SYNC_STAGES(SS), .DEB_LIMIT(DEB), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(btn_raw),
      .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
      .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready), .evt_ovf(evt_ovf));

   always #5 clk = ~clk;

   // reference: synced value = raw from SS edges ago; a level is accepted after
   // DEB enabled cycles in a row disagreeing with it; pending is a set of channels
   logic [3:0] m_hist [SS];
   int         m_run [4];
   logic [3:0] m_lvl, m_rise, m_fall, m_pend, m_s, m_clr;
   logic       m_ovf;

   function automatic logic [1:0] lowest(input logic [3:0] p);
      for (int i = 0; i < 4; i++) if (p[i]) return 2'(i);
      return 2'd0;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < SS; k++) m_hist[k] = '0;
         for (int c = 0; c < 4; c++) m_run[c] = 0;
         {m_lvl, m_rise, m_fall, m_pend, m_ovf} = '0;
      end else begin
         m_s   = m_hist[SS-1];
         m_clr = (m_pend != 0 && evt_ready) ? (4'b1 << lowest(m_pend)) : 4'b0;
         m_rise = '0;
         m_fall = '0;
         for (int c = 0; c < 4; c++) begin
            if (!ena) continue;
            if (m_s[c] == m_lvl[c]) m_run[c] = 0;
            else if (++m_run[c] == DEB) begin
               m_run[c]  = 0;
               m_lvl[c]  = m_s[c];
               m_rise[c] = m_s[c];
               m_fall[c] = !m_s[c];
            end
         end
         if ((m_rise & m_pend & ~m_clr) != 0) m_ovf = 1'b1;
         m_pend = (m_pend & ~m_clr) | m_rise;
         for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = btn_raw;
      end
   end

   wire [15:0] dut_v = {btn_level, btn_rise, btn_fall, evt_valid, evt_id, evt_ovf};
   wire [15:0] exp_v = {m_lvl, m_rise, m_fall, |m_pend, lowest(m_pend), m_ovf};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      chk("model", 32'(dut_v), 32'(exp_v));
   endtask

   typedef struct {
      logic [3:0] raw;
      logic       rdy;
      logic [3:0] lvl;
      logic [3:0] rise;
      logic       vld;
      logic [1:0] id;
   } vec_t;
   vec_t vec [8];

   logic seen;

   initial begin
      for (int k = 0; k < 5; k++) vec[k] = '{raw: 4'h1, rdy: 0, lvl: 4'h0, rise: 4'h0, vld: 0, id: 0};
      vec[5] = '{raw: 4'h1, rdy: 0, lvl: 4'h1, rise: 4'h1, vld: 1, id: 0};
      vec[6] = '{raw: 4'h1, rdy: 1, lvl: 4'h1, rise: 4'h0, vld: 0, id: 0};
      vec[7] = '{raw: 4'h1, rdy: 0, lvl: 4'h1, rise: 4'h0, vld: 0, id: 0};

      // reset hold
      repeat (10) tick();
      chk("reset_outputs", 32'(dut_v), 0);
      rst_n = 1;
      ena   = 1;
      repeat (3) tick();

      // single press through the synchroniser and debouncer, event consumed
      for (int k = 0; k < 8; k++) begin
         btn_raw   = vec[k].raw;
         evt_ready = vec[k].rdy;
         tick();
         chk($sformatf("vec%0d_level", k), 32'(btn_level), 32'(vec[k].lvl));
         chk($sformatf("vec%0d_rise", k), 32'(btn_rise), 32'(vec[k].rise));
         chk($sformatf("vec%0d_evt", k), 32'({evt_valid, evt_id}), 32'({vec[k].vld, vec[k].id}));
      end

      // bouncing channel is rejected
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         btn_raw[1] = ((c / 2) % 2) == 0;
         tick();
         seen |= btn_rise[1] | btn_fall[1] | evt_valid;
      end
      btn_raw[1] = 0;
      repeat (8) begin
         tick();
         seen |= btn_rise[1] | btn_fall[1] | evt_valid;
      end
      chk("bounce_level", 32'(btn_level[1]), 0);
      chk("bounce_quiet", 32'(seen), 0);

      // simultaneous rises served lowest index first
      btn_raw = '0;
      repeat (8) tick();
      evt_ready = 1;
      btn_raw   = 4'b0101;
      for (int n = 0; n < 20 && !evt_valid; n++) tick();
      chk("dual_rise", 32'(btn_rise), 32'h5);
      chk("dual_first", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd0}));
      tick();
      chk("dual_second", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd2}));
      tick();
      chk("dual_empty", 32'(evt_valid), 0);

      // press, release, press with no consumer -> coalesced
      btn_raw = '0;
      repeat (8) tick();
      evt_ready  = 0;
      btn_raw[0] = 1;
      for (int n = 0; n < 20 && !btn_level[0]; n++) tick();
      chk("ovf_press1", 32'(btn_level[0]), 1);
      chk("ovf_not_yet", 32'(evt_ovf), 0);
      btn_raw[0] = 0;
      for (int n = 0; n < 20 && !btn_fall[0]; n++) tick();
      chk("ovf_fall", 32'(btn_fall[0]), 1);
      btn_raw[0] = 1;
      for (int n = 0; n < 20 && !btn_rise[0]; n++) tick();
      chk("ovf_rise2", 32'(btn_rise[0]), 1);
      chk("ovf_set", 32'(evt_ovf), 1);
      chk("ovf_evt", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd0}));
      evt_ready = 1;
      tick();
      chk("ovf_single_evt", 32'(evt_valid), 0);
      chk("ovf_sticky", 32'(evt_ovf), 1);
      evt_ready = 0;

      // ena low mid-count freezes the debouncer
      btn_raw[3] = 1;
      repeat (4) tick();
      ena  = 0;
      seen = 0;
      repeat (10) begin
         tick();
         seen |= |btn_rise | |btn_fall;
      end
      chk("ena_hold_level", 32'(btn_level[3]), 0);
      chk("ena_no_pulse", 32'(seen), 0);
      ena = 1;
      tick();
      chk("ena_resume1", 32'(btn_level[3]), 0);
      tick();
      chk("ena_resume2", 32'({btn_level[3], btn_rise[3]}), 32'b11);

      // reset in the middle of a count
      btn_raw[3] = 0;
      repeat (3) tick();
      rst_n = 0;
      tick();
      chk("mid_reset", 32'(dut_v), 0);
      rst_n = 1;

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) btn_raw[b] = ~btn_raw[b];
         ena       = $urandom_range(9) != 0;
         evt_ready = $urandom_range(1);
         rst_n     = $urandom_range(299) != 0;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
